// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for the NoC switch allocator.
// Lock FSM encoding, request-field slicing and credit counter sizing.
package noc_alloc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned MAX_REQ_BITS   = 64;
    localparam int unsigned MAX_FIELD_BITS = 8;

    function automatic int unsigned credit_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

    // Extracts field idx of width bits from a packed array of target-port fields.
    function automatic logic [MAX_FIELD_BITS-1:0] port_field(
        input logic [MAX_REQ_BITS-1:0] vec,
        input int unsigned             idx,
        input int unsigned             bits
    );
        logic [MAX_REQ_BITS-1:0] sh;
        sh = vec >> (idx * bits);
        return sh[MAX_FIELD_BITS-1:0] & ~({MAX_FIELD_BITS{1'b1}} << bits);
    endfunction

endpackage

// File: rtl/output_matrix_arbiter.sv
// Purpose: matrix arbiter, wormhole lock FSM and credit counter for one output port.
// Latency: grant is combinational from req in the same cycle; state updates on the next edge.
// Backpressure: no grant while the downstream credit count is zero; optional starvation override (ARB_STARVATION_GUARD_EN).
module output_matrix_arbiter
    import noc_alloc_pkg::*;
#(
    parameter int unsigned IN_PORTS = 5,
    parameter int unsigned CREDITS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                on,
    input  logic [IN_PORTS-1:0] req,
    input  logic [IN_PORTS-1:0] req_tail,
`ifdef ARB_STARVATION_GUARD_EN
    input  logic [IN_PORTS-1:0] starved,
`endif
    input  logic                credit_in,
    output logic [IN_PORTS-1:0] grant,
    output logic                locked,
    output logic                credit_err
);

    localparam int unsigned CW = credit_width(CREDITS);
    localparam int unsigned OW = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;

    state_t                             state;
    logic [OW-1:0]                      owner;
    logic [CW-1:0]                      cnt;
    logic [IN_PORTS-1:0][IN_PORTS-1:0]  pri;
    logic [IN_PORTS-1:0]                eligible;
    logic [IN_PORTS-1:0]                winner;
    logic [OW-1:0]                      win_idx;
    logic                               win_tail;
`ifdef ARB_STARVATION_GUARD_EN
    logic [IN_PORTS-1:0]                st_req;
`endif

    always_comb begin
        eligible = (on && reset && cnt != '0) ? req : '0;
        winner   = '0;
        for (int unsigned i = 0; i < IN_PORTS; i++) begin
            winner[i] = eligible[i];
            for (int unsigned k = 0; k < IN_PORTS; k++) begin
                if (k != i && eligible[k] && pri[k][i]) winner[i] = 1'b0;
            end
        end
`ifdef ARB_STARVATION_GUARD_EN
        // Starved requesters bypass the matrix; isolate the lowest set bit.
        st_req = eligible & starved;
        if (st_req != '0) winner = st_req & (~st_req + IN_PORTS'(1));
`endif
        win_idx = '0;
        for (int unsigned i = 0; i < IN_PORTS; i++) begin
            if (winner[i]) win_idx = OW'(i);
        end
        win_tail = (winner & req_tail) != '0;
        grant    = '0;
        if (state == IDLE) grant = winner;
        else               grant[owner] = eligible[owner];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
        end else if (on) begin
            case (state)
                IDLE: begin
                    if (winner != '0 && !win_tail) begin
                        state <= LOCKED;
                        owner <= win_idx;
                    end
                end
                LOCKED: begin
                    if (grant[owner] && req_tail[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only head or single-flit wins in IDLE demote the winner below everyone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < IN_PORTS; i++)
                for (int unsigned k = 0; k < IN_PORTS; k++)
                    pri[i][k] <= (i > k);
        end else if (state == IDLE && winner != '0) begin
            for (int unsigned i = 0; i < IN_PORTS; i++)
                for (int unsigned k = 0; k < IN_PORTS; k++)
                    if (winner[i])      pri[i][k] <= 1'b0;
                    else if (winner[k]) pri[i][k] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else if (credit_in && grant == '0) begin
            if (cnt == CW'(CREDITS)) credit_err <= 1'b1;
            else                     cnt        <= cnt + CW'(1);
        end else if (!credit_in && grant != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: rtl/packet_switch_allocator.sv
// Purpose: NoC switch allocator; demuxes requests to per-output matrix arbiters and merges their grants.
// Latency: grants are combinational (0-cycle); out_locked/credit_err are registered.
// Backpressure: per-output credit gating and wormhole lock; ARB_STARVATION_GUARD_EN adds per-input wait counters.
module packet_switch_allocator
    import noc_alloc_pkg::*;
#(
    parameter int unsigned IN_PORTS      = 5,
    parameter int unsigned OUT_PORTS     = 5,
    parameter int unsigned OUT_PORT_BITS = 3,
    parameter int unsigned CREDITS       = 4,
    parameter int unsigned STARVE_LIMIT  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ON,
    input  logic [IN_PORTS-1:0]               requests,
    input  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports,
    input  logic [IN_PORTS-1:0]               req_tail,
    input  logic [OUT_PORTS-1:0]              credit_in,
    output logic [IN_PORTS-1:0]               grants,
    output logic [OUT_PORTS-1:0]              out_locked,
    output logic                              credit_err
);

    if ((1 << OUT_PORT_BITS) < OUT_PORTS || OUT_PORT_BITS > MAX_FIELD_BITS ||
        IN_PORTS * OUT_PORT_BITS > MAX_REQ_BITS || STARVE_LIMIT < 1) begin : g_param_check
        $error("packet_switch_allocator: inconsistent port/field parameters");
    end

    logic [MAX_REQ_BITS-1:0]             req_ports_ext;
    logic [OUT_PORTS-1:0][IN_PORTS-1:0]  req_dmx;
    logic [OUT_PORTS-1:0][IN_PORTS-1:0]  gnt_dmx;
    logic [OUT_PORTS-1:0]                err_vec;

    assign req_ports_ext = MAX_REQ_BITS'(req_ports);

    // Fields >= OUT_PORTS match no output and are silently dropped.
    always_comb begin
        req_dmx = '0;
        for (int unsigned o = 0; o < OUT_PORTS; o++)
            for (int unsigned i = 0; i < IN_PORTS; i++)
                req_dmx[o][i] = requests[i] &&
                    (port_field(req_ports_ext, i, OUT_PORT_BITS) == MAX_FIELD_BITS'(o));
    end

    always_comb begin
        grants = '0;
        for (int unsigned o = 0; o < OUT_PORTS; o++) grants = grants | gnt_dmx[o];
    end

    assign credit_err = |err_vec;

`ifdef ARB_STARVATION_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [IN_PORTS-1:0][SW-1:0] wait_cnt;
    logic [IN_PORTS-1:0]         starved;

    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < IN_PORTS; i++)
            starved[i] = (wait_cnt[i] == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (ON) begin
            for (int unsigned i = 0; i < IN_PORTS; i++) begin
                if (!requests[i] || grants[i])              wait_cnt[i] <= '0;
                else if (wait_cnt[i] != SW'(STARVE_LIMIT)) wait_cnt[i] <= wait_cnt[i] + SW'(1);
            end
        end
    end
`endif

    for (genvar o = 0; o < OUT_PORTS; o++) begin : g_out
        output_matrix_arbiter #(
            .IN_PORTS (IN_PORTS),
            .CREDITS  (CREDITS)
        ) u_arb (
            .clk        (clk),
            .reset      (reset),
            .on         (ON),
            .req        (req_dmx[o]),
            .req_tail   (req_tail),
`ifdef ARB_STARVATION_GUARD_EN
            .starved    (starved),
`endif
            .credit_in  (credit_in[o]),
            .grant      (gnt_dmx[o]),
            .locked     (out_locked[o]),
            .credit_err (err_vec[o])
        );
    end

endmodule

// File: tb/tb_packet_switch_allocator.sv
// Directed self-checking bench for packet_switch_allocator (5x5, CREDITS=4, STARVE_LIMIT=3).
module tb_packet_switch_allocator;

    logic        clk = 1'b0;
    logic        reset;
    logic        ON;
    logic [4:0]  requests;
    logic [14:0] req_ports;
    logic [4:0]  req_tail;
    logic [4:0]  credit_in;
    logic [4:0]  grants;
    logic [4:0]  out_locked;
    logic        credit_err;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp6 [5];

    always #5 clk = ~clk;

    packet_switch_allocator #(
        .IN_PORTS      (5),
        .OUT_PORTS     (5),
        .OUT_PORT_BITS (3),
        .CREDITS       (4),
        .STARVE_LIMIT  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ON         (ON),
        .requests   (requests),
        .req_ports  (req_ports),
        .req_tail   (req_tail),
        .credit_in  (credit_in),
        .grants     (grants),
        .out_locked (out_locked),
        .credit_err (credit_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [14:0] mk_ports(input int p4, input int p3, input int p2, input int p1, input int p0);
        return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic drive(input logic [4:0] r, input logic [14:0] p, input logic [4:0] t, input logic [4:0] c);
        requests  = r;
        req_ports = p;
        req_tail  = t;
        credit_in = c;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ARB_STARVATION_GUARD_EN
        exp6[0] = 5'b10000; exp6[1] = 5'b01000; exp6[2] = 5'b00100; exp6[3] = 5'b00001; exp6[4] = 5'b00010;
`else
        exp6[0] = 5'b10000; exp6[1] = 5'b01000; exp6[2] = 5'b00100; exp6[3] = 5'b00010; exp6[4] = 5'b00001;
`endif
        reset = 1'b0;
        ON    = 1'b0;
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        chk("reset_grants", grants, 0);
        chk("reset_locked", out_locked, 0);
        chk("reset_err", credit_err, 0);
        ON = 1'b1;
        drive(5'b11111, mk_ports(0, 0, 0, 0, 0), 5'b11111, 5'b0);
        chk("reset_forces_no_grant", grants, 0);
        @(negedge clk);
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        reset = 1'b1;
        #1;

        // Test 1: inputs 0 and 2 to output 1, single flits
        drive(5'b00101, mk_ports(0, 0, 1, 0, 1), 5'b11111, 5'b0);
        chk("t1_first", grants, 5'b00100);
        cyc();
        chk("t1_second", grants, 5'b00001);
        cyc();
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b00010);
        cyc();
        cyc();
        chk("t4_no_err_at_full", credit_err, 0);

        // Test 4: overflow, then simultaneous grant+credit
        cyc();
        chk("t4_overflow_err", credit_err, 1);
        drive(5'b00010, mk_ports(0, 0, 0, 1, 0), 5'b11111, 5'b00010);
        chk("t4_grant_with_credit", grants, 5'b00010);
        cyc();
        chk("t4_err_sticky", credit_err, 1);
        drive(5'b00010, mk_ports(0, 0, 0, 1, 0), 5'b11111, 5'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_grant_%0d", k), grants, 5'b00010);
            cyc();
        end
        chk("t4_exhausted", grants, 0);
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b00010);
        repeat (4) cyc();
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        cyc();

        // Test 3: credit exhaustion on output 0
        drive(5'b10000, mk_ports(0, 0, 0, 0, 0), 5'b11111, 5'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_grant_%0d", k), grants, 5'b10000);
            cyc();
        end
        chk("t3_no_credit_a", grants, 0);
        cyc();
        chk("t3_no_credit_b", grants, 0);
        drive(5'b10000, mk_ports(0, 0, 0, 0, 0), 5'b11111, 5'b00001);
        chk("t3_pulse_cycle", grants, 0);
        cyc();
        drive(5'b10000, mk_ports(0, 0, 0, 0, 0), 5'b11111, 5'b0);
        chk("t3_extra_grant", grants, 5'b10000);
        cyc();
        chk("t3_after_extra", grants, 0);
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b00001);
        repeat (4) cyc();
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        cyc();

        // Test 2: 4-flit packet from input 3 to output 2, input 0 waiting
        drive(5'b01001, mk_ports(0, 2, 0, 0, 2), 5'b00001, 5'b0);
        chk("t2_head", grants, 5'b01000);
        chk("t2_unlocked_at_head", out_locked, 0);
        cyc();
        chk("t2_locked", out_locked, 5'b00100);
        drive(5'b01001, mk_ports(0, 2, 0, 0, 2), 5'b00001, 5'b00100);
        chk("t2_body1", grants, 5'b01000);
        cyc();
        drive(5'b00001, mk_ports(0, 2, 0, 0, 2), 5'b00001, 5'b0);
        chk("t2_owner_drop", grants, 0);
        chk("t2_still_locked", out_locked, 5'b00100);
        cyc();
        drive(5'b01001, mk_ports(0, 2, 0, 0, 2), 5'b00001, 5'b00100);
        chk("t2_body2", grants, 5'b01000);
        cyc();
        drive(5'b01001, mk_ports(0, 2, 0, 0, 2), 5'b01001, 5'b00100);
        chk("t2_tail", grants, 5'b01000);
        chk("t2_locked_at_tail", out_locked, 5'b00100);
        cyc();
        drive(5'b00001, mk_ports(0, 2, 0, 0, 2), 5'b00001, 5'b0);
        chk("t2_released", out_locked, 0);
        chk("t2_next_input", grants, 5'b00001);
        cyc();
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        cyc();

        // Test 5: reset in the middle of a locked packet on output 3
        drive(5'b10010, mk_ports(3, 0, 0, 3, 0), 5'b00010, 5'b0);
        chk("t5_head", grants, 5'b10000);
        cyc();
        chk("t5_locked", out_locked, 5'b01000);
        chk("t5_body_blocks_other", grants, 5'b10000);
        reset = 1'b0;
        #1;
        chk("t5_reset_grants", grants, 0);
        chk("t5_reset_locked", out_locked, 0);
        chk("t5_reset_err", credit_err, 0);
        cyc();
        reset = 1'b1;
        drive(5'b10010, mk_ports(3, 0, 0, 3, 0), 5'b11111, 5'b0);
        chk("t5_reset_priority", grants, 5'b10000);
        cyc();
        chk("t5_second", grants, 5'b00010);
        cyc();
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        cyc();

        // Test 6: all inputs contend for output 4, credit returned every cycle
        drive(5'b11111, mk_ports(4, 4, 4, 4, 4), 5'b11111, 5'b10000);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t6_order_%0d", k), grants, exp6[k]);
            cyc();
        end
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        cyc();

        // Enable gating and out-of-range target
        ON = 1'b0;
        drive(5'b00100, mk_ports(0, 0, 0, 0, 0), 5'b11111, 5'b0);
        chk("on_low_no_grant", grants, 0);
        cyc();
        chk("on_low_still_none", grants, 0);
        ON = 1'b1;
        #1;
        chk("on_restored", grants, 5'b00100);
        cyc();
        drive(5'b01000, mk_ports(0, 6, 0, 0, 0), 5'b11111, 5'b0);
        chk("invalid_port", grants, 0);
        cyc();
        chk("invalid_port_locked", out_locked, 0);
        drive(5'b0, mk_ports(0, 0, 0, 0, 0), 5'b0, 5'b0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
